ssvga_dpram_param: RTL and testbench
====================================

Name: ssvga_dpram_param

Overview:
- Parametrised single-clock dual-port RAM for the VGA subsystem. Successor to the fixed 512x8 / 256x16 line-buffer RAM.
- Port A has a narrow data width and is typically on the Wishbone side. Port B has a wide data width (power-of-two multiple of A), has per-lane write enables and is typically on the pixel side.
- Adds:
  - selectable read-during-write mode
  - optional output pipeline register
  - read-valid strobes
  - same-cycle write-collision detection with deterministic priority.

Parameters:
- A_DW, 8: port A data width; one lane = A_DW bits.
- RATIO_LOG2, 1: log2(B_DW/A_DW); range 0..3.
- B_AW, 8: port B address width (words).
- RDW_MODE, 1: same-port read-during-write; 1 = write-first (new data), 0 = read-first (old data).
- OUT_REG, 0: 1 adds one output register stage on both ports.
- Derived, not overridable:
  - LANES = 1<<RATIO_LOG2
  - B_DW = A_DW*LANES
  - A_AW = B_AW+RATIO_LOG2
  - DEPTH = 1<<A_AW lanes

Ports:
- clk  in  1  single clock for both ports
- rst_n  in  1  synchronous, active-low reset
- ena  in  1  port A enable
- wea  in  1  port A write enable (qualified by ena)
- addra  in  A_AW  port A lane address
- dia  in  A_DW  port A write data
- doa  out  A_DW  port A read data, registered
- vala  out  1  port A read-data valid strobe
- enb  in  1  port B enable
- web  in  LANES  port B per-lane write enables (qualified by enb)
- addrb  in  B_AW  port B word address
- dib  in  B_DW  port B write data
- dob  out  B_DW  port B read data, registered
- valb  out  1  port B read-data valid strobe
- coll  out  1  registered write-collision pulse

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - doa, dob, vala, valb, coll and all pipeline stages go to 0.
  - Memory contents are retained.
  - ena/enb are ignored in that cycle: no write, no read launched.
- Mapping: port B word W, lane i occupies lane address {W,i[RATIO_LOG2-1:0]}. Lane 0 is bits [A_DW-1:0] (little-endian).
- Read launch:
  - Every cycle with enable=1 launches a read, including write cycles.
  - With web=0 the port B access is a pure read.
- Latency:
  - OUT_REG=0: data on doa/dob and val* high exactly 1 cycle after launch.
  - OUT_REG=1: 2 cycles after launch.
  - val* is a one-cycle pulse per launch. Back-to-back launches give back-to-back valid data (full throughput).
  - Outputs hold their last value when no read completes.
- Same-port read-during-write:
  - RDW_MODE=1: returned data = new data. On port B, written lanes show dib and unwritten lanes show the stored value.
  - RDW_MODE=0: returned data = pre-write contents.
- Cross-port read of a location written the same cycle by the other port always returns the pre-write contents.
- Write collision: A writes lane L and B writes lane L in the same cycle.
  - Port B data is stored.
  - coll=1 in the next cycle only; not affected by OUT_REG.
  - A and B writing different lanes of the same word: both writes take effect, no collision.
- Reset asserted while reads are in flight (OUT_REG=1): in-flight data and valids are discarded; no val* pulse emerges after reset release.
- Address wrap: none. All addresses are in range by construction.
- RATIO_LOG2=0: B is a symmetric port; web is 1 bit.

Decomposition:
- Shared package ssvga_pkg:
  - RDW_WRITE_FIRST=1, RDW_READ_FIRST=0
  - the derived-width functions (LANES, B_DW, A_AW)
- One sub-module, ssvga_dpram_outpipe: the per-port output register / valid pipeline, instantiated twice with width parameter. It is a pass-through when OUT_REG=0.
- Storage is a single lane-wide array in the top module, written by both ports.

Test Plan (defaults unless stated):
1. Width mapping:
   - Stimulus: A writes 0x11 @0x00A and 0x22 @0x00B; then B reads word 0x05.
   - Required: dob=0x2211 with valb 1 cycle later. Then A reads 0x00B and gets doa=0x22.
2. Lane enables and write-first:
   - Stimulus: preload word 0x10=0xAAAA; B writes dib=0x1234 with web=2'b01 @0x10 (RDW_MODE=1).
   - Required: same-launch dob=0xAA34; a later read returns 0xAA34.
   - With RDW_MODE=0, the same-launch read returns 0xAAAA.
3. Collision:
   - Stimulus: same cycle, A writes 0x55 @0x020 and B writes 0xBEEF, web=2'b11 @0x10.
   - Required: coll pulses 1 cycle; readback of word 0x10 = 0xBEEF.
   - Repeat with web=2'b10: no coll; readback 0xBE55.
4. Pipeline (OUT_REG=1):
   - Stimulus: B read launches on 3 consecutive cycles at 0x01, 0x02, 0x03.
   - Required: valb high in cycles 2, 3 and 4 with matching data in order; doa/dob hold afterwards.
5. Reset mid-flight:
   - Stimulus: OUT_REG=1; launch a read, then assert rst_n=0 the next cycle with a write enabled.
   - Required: no valb pulse; dob=0; the written location is unchanged; memory otherwise retains its contents.
6. Cross-port:
   - Stimulus: A writes 0x77 @0x030 while B reads word 0x18 in the same cycle.
   - Required: dob shows the old lane-0 value; the next B read shows 0x77 in lane 0.

Source files
------------

// File: rtl/ssvga_pkg.sv
// Shared constants and derived-width helpers for the VGA dual-port RAM family.
package ssvga_pkg;

  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_READ_FIRST  = 0;

  function automatic int lanes_f(input int ratio_log2);
    return 1 << ratio_log2;
  endfunction

  function automatic int b_dw_f(input int a_dw, input int ratio_log2);
    return a_dw * lanes_f(ratio_log2);
  endfunction

  function automatic int a_aw_f(input int b_aw, input int ratio_log2);
    return b_aw + ratio_log2;
  endfunction

endpackage

// File: rtl/ssvga_dpram_outpipe.sv
// Per-port read-data register with valid strobe, plus an optional second stage.
module ssvga_dpram_outpipe #(
  parameter int DW      = 8,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          launch,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          vout
);

  logic [DW-1:0] s1_dat_r;
  logic          s1_val_r;

  // first stage: capture the array read on every launch, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_dat_r <= '0;
      s1_val_r <= 1'b0;
    end else begin
      s1_val_r <= launch;
      if (launch) begin
        s1_dat_r <= din;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [DW-1:0] s2_dat_r;
      logic          s2_val_r;

      // optional second stage: only a completed first-stage read moves data on
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_dat_r <= '0;
          s2_val_r <= 1'b0;
        end else begin
          s2_val_r <= s1_val_r;
          if (s1_val_r) begin
            s2_dat_r <= s1_dat_r;
          end
        end
      end

      assign dout = s2_dat_r;
      assign vout = s2_val_r;
    end else begin : g_pass
      assign dout = s1_dat_r;
      assign vout = s1_val_r;
    end
  endgenerate

endmodule

// File: rtl/ssvga_dpram_param.sv
// Single-clock dual-port RAM: narrow lane port A, wide multi-lane port B,
// selectable read-during-write, optional output register and collision pulse.
module ssvga_dpram_param
  import ssvga_pkg::*;
#(
  parameter  int A_DW       = 8,
  parameter  int RATIO_LOG2 = 1,
  parameter  int B_AW       = 8,
  parameter  int RDW_MODE   = 1,
  parameter  int OUT_REG    = 0,
  localparam int LANES      = lanes_f(RATIO_LOG2),
  localparam int B_DW       = b_dw_f(A_DW, RATIO_LOG2),
  localparam int A_AW       = a_aw_f(B_AW, RATIO_LOG2),
  localparam int DEPTH      = 1 << A_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             wea,
  input  logic [A_AW-1:0]  addra,
  input  logic [A_DW-1:0]  dia,
  output logic [A_DW-1:0]  doa,
  output logic             vala,
  input  logic             enb,
  input  logic [LANES-1:0] web,
  input  logic [B_AW-1:0]  addrb,
  input  logic [B_DW-1:0]  dib,
  output logic [B_DW-1:0]  dob,
  output logic             valb,
  output logic             coll
);

  logic [A_DW-1:0]  mem_r [DEPTH];
  logic             a_we_s;
  logic [LANES-1:0] b_we_s;
  logic [A_DW-1:0]  rda_s;
  logic [B_DW-1:0]  rdb_s;
  logic             coll_s;
  logic             coll_r;

  // lane address of lane i within port B word w (lane 0 is the low lane)
  function automatic logic [A_AW-1:0] b_lane_addr(input logic [B_AW-1:0] w, input int i);
    return (A_AW'(w) << RATIO_LOG2) | A_AW'(i);
  endfunction

  assign a_we_s = ena & wea;
  assign b_we_s = web & {LANES{enb}};

  // storage; B is written after A so B wins a same-lane collision
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (a_we_s) begin
        mem_r[addra] <= dia;
      end
      for (int i = 0; i < LANES; i++) begin
        if (b_we_s[i]) begin
          mem_r[b_lane_addr(addrb, i)] <= dib[i*A_DW +: A_DW];
        end
      end
    end
  end

  // read mux: array contents are always pre-write, so cross-port reads see old data
  always_comb begin
    rda_s  = '0;
    rdb_s  = '0;
    coll_s = 1'b0;
    if ((RDW_MODE == RDW_WRITE_FIRST) && a_we_s) begin
      rda_s = dia;
    end else begin
      rda_s = mem_r[addra];
    end
    for (int i = 0; i < LANES; i++) begin
      if ((RDW_MODE == RDW_WRITE_FIRST) && b_we_s[i]) begin
        rdb_s[i*A_DW +: A_DW] = dib[i*A_DW +: A_DW];
      end else begin
        rdb_s[i*A_DW +: A_DW] = mem_r[b_lane_addr(addrb, i)];
      end
      coll_s = coll_s | (a_we_s & b_we_s[i] & (b_lane_addr(addrb, i) == addra));
    end
  end

  // collision pulse bypasses the output pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coll_r <= 1'b0;
    end else begin
      coll_r <= coll_s;
    end
  end

  assign coll = coll_r;

  ssvga_dpram_outpipe #(
    .DW      (A_DW),
    .OUT_REG (OUT_REG)
  ) u_pipe_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .launch (ena),
    .din    (rda_s),
    .dout   (doa),
    .vout   (vala)
  );

  ssvga_dpram_outpipe #(
    .DW      (B_DW),
    .OUT_REG (OUT_REG)
  ) u_pipe_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .launch (enb),
    .din    (rdb_s),
    .dout   (dob),
    .vout   (valb)
  );

endmodule

// File: tb/tb_ssvga_dpram_param.sv
// Directed bench: write-first, read-first and pipelined instances share one stimulus stream.
module tb_ssvga_dpram_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, wea, enb;
  logic [8:0]  addra;
  logic [7:0]  dia;
  logic [1:0]  web;
  logic [7:0]  addrb;
  logic [15:0] dib;

  logic [7:0]  doa, doa_rf, doa_p;
  logic [15:0] dob, dob_rf, dob_p;
  logic        vala, vala_rf, vala_p;
  logic        valb, valb_rf, valb_p;
  logic        coll, coll_rf, coll_p;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ssvga_dpram_param u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .doa(doa), .vala(vala), .enb(enb), .web(web), .addrb(addrb), .dib(dib),
    .dob(dob), .valb(valb), .coll(coll)
  );

  ssvga_dpram_param #(.RDW_MODE(0)) u_dut_rf (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .doa(doa_rf), .vala(vala_rf), .enb(enb), .web(web), .addrb(addrb), .dib(dib),
    .dob(dob_rf), .valb(valb_rf), .coll(coll_rf)
  );

  ssvga_dpram_param #(.OUT_REG(1)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .doa(doa_p), .vala(vala_p), .enb(enb), .web(web), .addrb(addrb), .dib(dib),
    .dob(dob_p), .valb(valb_p), .coll(coll_p)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 2'b00;
  endtask

  task automatic a_op(input logic we, input logic [8:0] ad, input logic [7:0] d);
    ena = 1'b1; wea = we; addra = ad; dia = d;
  endtask

  task automatic b_op(input logic [1:0] we, input logic [7:0] ad, input logic [15:0] d);
    enb = 1'b1; web = we; addrb = ad; dib = d;
  endtask

  initial begin
    rst_n = 1'b0; addra = 9'h000; dia = 8'h00; addrb = 8'h00; dib = 16'h0000;
    idle();
    step(); step();
    chk("rst_doa",  32'(doa),  32'h0);   chk("rst_dob",  32'(dob),  32'h0);
    chk("rst_vala", 32'(vala), 32'h0);   chk("rst_valb", 32'(valb), 32'h0);
    chk("rst_coll", 32'(coll), 32'h0);
    chk("rst_rf",   32'({doa_rf, dob_rf, vala_rf, valb_rf, coll_rf}), 32'h0);
    chk("rst_p",    32'({doa_p, dob_p, vala_p, valb_p, coll_p}), 32'h0);
    rst_n = 1'b1;

    // width mapping
    a_op(1'b1, 9'h00A, 8'h11); step();
    chk("a_wf_11", 32'(doa), 32'h11);  chk("a_vala", 32'(vala), 32'h1);
    a_op(1'b1, 9'h00B, 8'h22); step();
    chk("a_wf_22", 32'(doa), 32'h22);
    idle(); b_op(2'b00, 8'h05, 16'h0000); step();
    chk("map_dob", 32'(dob), 32'h2211); chk("map_valb", 32'(valb), 32'h1);
    chk("map_vala_idle", 32'(vala), 32'h0); chk("map_dob_rf", 32'(dob_rf), 32'h2211);
    idle(); step();
    chk("hold_valb", 32'(valb), 32'h0); chk("hold_dob", 32'(dob), 32'h2211);
    chk("p_map_dob", 32'(dob_p), 32'h2211); chk("p_map_valb", 32'(valb_p), 32'h1);
    a_op(1'b0, 9'h00B, 8'h00); step();
    chk("a_rd_22", 32'(doa), 32'h22); chk("a_rd_vala", 32'(vala), 32'h1);
    chk("a_rd_22_rf", 32'(doa_rf), 32'h22);

    // lane enables and read-during-write mode
    idle(); b_op(2'b11, 8'h10, 16'hAAAA); step();
    idle(); b_op(2'b01, 8'h10, 16'h1234); step();
    chk("rdw_wf", 32'(dob), 32'hAA34); chk("rdw_rf", 32'(dob_rf), 32'hAAAA);
    idle(); b_op(2'b00, 8'h10, 16'h0000); step();
    chk("lane_rb", 32'(dob), 32'hAA34); chk("lane_rb_rf", 32'(dob_rf), 32'hAA34);

    // collision
    idle(); a_op(1'b1, 9'h020, 8'h55); b_op(2'b11, 8'h10, 16'hBEEF); step();
    chk("coll_hi", 32'(coll), 32'h1); chk("coll_hi_p", 32'(coll_p), 32'h1);
    idle(); step();
    chk("coll_lo", 32'(coll), 32'h0); chk("coll_lo_p", 32'(coll_p), 32'h0);
    a_op(1'b0, 9'h020, 8'h00); b_op(2'b00, 8'h10, 16'h0000); step();
    chk("coll_rb", 32'(dob), 32'hBEEF); chk("coll_rb_a", 32'(doa), 32'hEF);
    idle(); a_op(1'b1, 9'h020, 8'h55); b_op(2'b10, 8'h10, 16'hBEEF); step();
    chk("nocoll", 32'(coll), 32'h0);
    idle(); b_op(2'b00, 8'h10, 16'h0000); step();
    chk("nocoll_rb", 32'(dob), 32'hBE55);

    // output pipeline
    idle(); b_op(2'b11, 8'h01, 16'h1111); step();
    b_op(2'b11, 8'h02, 16'h2222); step();
    b_op(2'b11, 8'h03, 16'h3333); step();
    idle(); step(); step();
    b_op(2'b00, 8'h01, 16'h0000); step();
    chk("p_c1_valb", 32'(valb_p), 32'h0); chk("np_c1_dob", 32'(dob), 32'h1111);
    b_op(2'b00, 8'h02, 16'h0000); step();
    chk("p_c2_valb", 32'(valb_p), 32'h1); chk("p_c2_dob", 32'(dob_p), 32'h1111);
    b_op(2'b00, 8'h03, 16'h0000); step();
    chk("p_c3_valb", 32'(valb_p), 32'h1); chk("p_c3_dob", 32'(dob_p), 32'h2222);
    idle(); step();
    chk("p_c4_valb", 32'(valb_p), 32'h1); chk("p_c4_dob", 32'(dob_p), 32'h3333);
    step();
    chk("p_c5_valb", 32'(valb_p), 32'h0); chk("p_c5_dob", 32'(dob_p), 32'h3333);

    // reset with a read in flight and writes requested
    b_op(2'b00, 8'h01, 16'h0000); step();
    rst_n = 1'b0; b_op(2'b11, 8'h02, 16'hDEAD); a_op(1'b1, 9'h006, 8'h99); step();
    chk("mr_valb_p", 32'(valb_p), 32'h0); chk("mr_dob_p", 32'(dob_p), 32'h0);
    chk("mr_dob", 32'(dob), 32'h0);       chk("mr_valb", 32'(valb), 32'h0);
    rst_n = 1'b1; idle(); step();
    chk("mr_nopulse", 32'(valb_p), 32'h0); chk("mr_dob_p2", 32'(dob_p), 32'h0);
    b_op(2'b00, 8'h02, 16'h0000); step();
    chk("mr_keep2", 32'(dob), 32'h2222);
    b_op(2'b00, 8'h03, 16'h0000); step();
    chk("mr_keep3", 32'(dob), 32'h3333);

    // cross-port read of a location written the same cycle
    idle(); b_op(2'b11, 8'h18, 16'hC3C3); step();
    idle(); a_op(1'b1, 9'h030, 8'h77); b_op(2'b00, 8'h18, 16'h0000); step();
    chk("xp_old", 32'(dob), 32'hC3C3); chk("xp_old_rf", 32'(dob_rf), 32'hC3C3);
    idle(); b_op(2'b00, 8'h18, 16'h0000); step();
    chk("xp_new", 32'(dob), 32'hC377);

    idle(); step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
